// File: rtl/bldc_commutator_if.sv
// Command/status bundle between the speed/ADC front-end (master) and the
// BLDC commutator (slave).
interface bldc_commutator_if #(
  parameter int unsigned PWM_W  = 8,
  parameter int unsigned STEP_W = 24
) ();
  logic              enable;
  logic              fwd;
  logic              mode;
  logic [2:0]        hall;
  logic [PWM_W-1:0]  duty;
  logic [STEP_W-1:0] step_period;
  logic              fault_clr;
  logic [5:0]        gate;
  logic [2:0]        sector;
  logic              fault;

  modport master (
    output enable, fwd, mode, hall, duty, step_period, fault_clr,
    input  gate, sector, fault
  );

  modport slave (
    input  enable, fwd, mode, hall, duty, step_period, fault_clr,
    output gate, sector, fault
  );
endinterface

// File: rtl/bldc_commutator.sv
// 6-step BLDC commutator: hall-sensored or open-loop stepping, dead-time,
// high-side PWM, invalid-hall/stall fault. Optional hall glitch filter: HALL_FILTER_EN.
module bldc_commutator #(
  parameter int unsigned PWM_W    = 8,
  parameter int unsigned DEADTIME = 50,
  parameter int unsigned STEP_W   = 24,
  parameter int unsigned TIMEOUT  = 1000000,
  parameter int unsigned FILT_LEN = 4
) (
  input logic              clk,
  input logic              rst_n,
  bldc_commutator_if.slave bus
);
  typedef enum logic [1:0] {OFF, DEAD, DRIVE, FAULT} state_t;

  localparam int unsigned DT_W = $clog2(DEADTIME + 1);
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  localparam logic [STEP_W-1:0] STEP_MIN = STEP_W'(DEADTIME + 1);

  state_t            state;
  logic [5:0]        gate_q;
  logic [2:0]        sector_q;
  logic              fault_q;
  logic [DT_W-1:0]   dead_cnt;
  logic [TO_W-1:0]   stall_cnt;
  logic [2:0]        hall_s1, hall_s2, hall_q, hall_prev;
  logic              fwd_q, mode_q;
  logic [PWM_W-1:0]  pwm_cnt, duty_q;
  logic              pwm_on;
  logic [STEP_W-1:0] step_cnt, step_limit;
  logic [2:0]        ol_sector, hall_sector, target;
  logic              hall_valid, ol_run, stalled, sens_fault_dead, sens_fault_drive;

  function automatic logic [2:0] hall_to_sector(input logic [2:0] h);
    case (h)
      3'b001:  return 3'd1;
      3'b000:  return 3'd2;
      3'b100:  return 3'd3;
      3'b110:  return 3'd4;
      3'b111:  return 3'd5;
      3'b011:  return 3'd6;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [5:0] sector_pattern(input logic [2:0] s);
    case (s)
      3'd1:    return 6'b100001;
      3'd2:    return 6'b100100;
      3'd3:    return 6'b000110;
      3'd4:    return 6'b010010;
      3'd5:    return 6'b011000;
      3'd6:    return 6'b001001;
      default: return 6'b000000;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hall_s1 <= '0;
      hall_s2 <= '0;
    end else begin
      hall_s1 <= bus.hall;
      hall_s2 <= hall_s1;
    end
  end

`ifdef HALL_FILTER_EN
  localparam int unsigned FC_W = (FILT_LEN > 2) ? $clog2(FILT_LEN - 1) : 1;
  logic [2:0]      hall_p, hall_f;
  logic [FC_W-1:0] filt_cnt;

  // hall_f follows hall_s2 only after FILT_LEN identical consecutive samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hall_p   <= '0;
      hall_f   <= '0;
      filt_cnt <= '0;
    end else begin
      hall_p <= hall_s2;
      if (hall_s2 != hall_p)
        filt_cnt <= '0;
      else if (filt_cnt == FC_W'(FILT_LEN - 2))
        hall_f <= hall_s2;
      else
        filt_cnt <= filt_cnt + 1'b1;
    end
  end
  assign hall_q = hall_f;
`else
  assign hall_q = hall_s2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      duty_q  <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (pwm_cnt == '1)
        duty_q <= bus.duty;
    end
  end
  assign pwm_on = (pwm_cnt < duty_q);

  always_comb begin
    hall_sector = hall_to_sector(hall_q);
    hall_valid  = (hall_sector != 3'd0);
    step_limit  = (bus.step_period < STEP_MIN) ? STEP_MIN : bus.step_period;
    ol_run      = bus.mode && ((state == DEAD) || (state == DRIVE) || ((state == OFF) && bus.enable));
    stalled     = (stall_cnt == TO_W'(TIMEOUT - 1)) && (hall_q == hall_prev);
    sens_fault_dead  = !bus.mode && !hall_valid;
    sens_fault_drive = !bus.mode && (!hall_valid || stalled);
    if (bus.mode)
      target = ol_sector;
    else if (!hall_valid)
      target = 3'd0;
    else if (bus.fwd)
      target = hall_sector;
    else
      target = (hall_sector > 3'd3) ? hall_sector - 3'd3 : hall_sector + 3'd3;
  end

  // Step timer also counts on the OFF->DEAD edge so every sector lasts exactly step_limit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt  <= '0;
      ol_sector <= 3'd1;
    end else if (!ol_run) begin
      step_cnt  <= '0;
      ol_sector <= 3'd1;
    end else if (step_cnt >= step_limit - 1'b1) begin
      step_cnt <= '0;
      if (bus.fwd)
        ol_sector <= (ol_sector == 3'd6) ? 3'd1 : ol_sector + 3'd1;
      else
        ol_sector <= (ol_sector == 3'd1) ? 3'd6 : ol_sector - 3'd1;
    end else begin
      step_cnt <= step_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= OFF;
      gate_q    <= '0;
      sector_q  <= '0;
      fault_q   <= 1'b0;
      dead_cnt  <= '0;
      stall_cnt <= '0;
      hall_prev <= '0;
      fwd_q     <= 1'b0;
      mode_q    <= 1'b0;
    end else begin
      fwd_q     <= bus.fwd;
      mode_q    <= bus.mode;
      hall_prev <= hall_q;
      stall_cnt <= '0;
      case (state)
        OFF: begin
          gate_q   <= '0;
          sector_q <= '0;
          fault_q  <= 1'b0;
          if (bus.enable) begin
            state    <= DEAD;
            dead_cnt <= '0;
          end
        end
        DEAD: begin
          gate_q <= '0;
          if (sens_fault_dead) begin
            state    <= FAULT;
            fault_q  <= 1'b1;
            sector_q <= '0;
          end else if (!bus.enable) begin
            state    <= OFF;
            sector_q <= '0;
          end else if (dead_cnt == DT_W'(DEADTIME - 1)) begin
            state    <= DRIVE;
            sector_q <= target;
            gate_q   <= sector_pattern(target) & (pwm_on ? 6'b111111 : 6'b010101);
          end else begin
            dead_cnt <= dead_cnt + 1'b1;
          end
        end
        DRIVE: begin
          if (sens_fault_drive) begin
            state    <= FAULT;
            fault_q  <= 1'b1;
            gate_q   <= '0;
            sector_q <= '0;
          end else if (!bus.enable) begin
            state    <= OFF;
            gate_q   <= '0;
            sector_q <= '0;
          end else if ((target != sector_q) || (bus.fwd != fwd_q) || (bus.mode != mode_q)) begin
            state    <= DEAD;
            dead_cnt <= '0;
            gate_q   <= '0;
          end else begin
            gate_q <= sector_pattern(sector_q) & (pwm_on ? 6'b111111 : 6'b010101);
            if (!bus.mode && (hall_q == hall_prev))
              stall_cnt <= stall_cnt + 1'b1;
          end
        end
        FAULT: begin
          gate_q   <= '0;
          sector_q <= '0;
          fault_q  <= 1'b1;
          if (bus.fault_clr && !bus.enable) begin
            state   <= OFF;
            fault_q <= 1'b0;
          end
        end
        default: state <= OFF;
      endcase
    end
  end

  assign bus.gate   = gate_q;
  assign bus.sector = sector_q;
  assign bus.fault  = fault_q;
endmodule

// File: tb/tb_bldc_commutator.sv
// Self-checking bench for bldc_commutator: vector table for the sensored map,
// hand sequences for dead-time, open-loop stepping, PWM, faults and reset.
module tb_bldc_commutator;
  localparam int unsigned PWM_W    = 8;
  localparam int unsigned DEADTIME = 50;
  localparam int unsigned STEP_W   = 24;
  localparam int unsigned TIMEOUT  = 1000;
  localparam int unsigned FILT_LEN = 4;
  localparam int unsigned STEP     = 1000;
`ifdef HALL_FILTER_EN
  localparam int unsigned HLAT = 3 + FILT_LEN;
`else
  localparam int unsigned HLAT = 3;
`endif
  localparam int unsigned SETTLE = HLAT + DEADTIME + 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  bldc_commutator_if #(.PWM_W(PWM_W), .STEP_W(STEP_W)) bif ();

  bldc_commutator #(
    .PWM_W(PWM_W), .DEADTIME(DEADTIME), .STEP_W(STEP_W),
    .TIMEOUT(TIMEOUT), .FILT_LEN(FILT_LEN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       fwd;
    logic [2:0] hall;
    logic [2:0] sector;
    logic [5:0] pattern;
  } vec_t;

  typedef struct {
    string      name;
    logic [2:0] sector;
    logic [5:0] pattern;
  } exp_t;

  vec_t vecs[12];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic gate_or(input int unsigned n, output logic [5:0] acc);
    acc = '0;
    repeat (n) begin
      tick(1);
      acc |= bif.gate;
    end
  endtask

  task automatic count_high(input int unsigned n, output int cnt);
    cnt = 0;
    repeat (n) begin
      tick(1);
      if (bif.gate[5]) cnt++;
    end
  endtask

  initial begin
    logic [5:0] acc;
    exp_t       e;
    int         cnt;
    int unsigned el;

    vecs[0]  = '{1'b1, 3'b001, 3'd1, 6'b100001};
    vecs[1]  = '{1'b1, 3'b000, 3'd2, 6'b100100};
    vecs[2]  = '{1'b1, 3'b100, 3'd3, 6'b000110};
    vecs[3]  = '{1'b1, 3'b110, 3'd4, 6'b010010};
    vecs[4]  = '{1'b1, 3'b111, 3'd5, 6'b011000};
    vecs[5]  = '{1'b1, 3'b011, 3'd6, 6'b001001};
    vecs[6]  = '{1'b0, 3'b001, 3'd4, 6'b010010};
    vecs[7]  = '{1'b0, 3'b000, 3'd5, 6'b011000};
    vecs[8]  = '{1'b0, 3'b100, 3'd6, 6'b001001};
    vecs[9]  = '{1'b0, 3'b110, 3'd1, 6'b100001};
    vecs[10] = '{1'b0, 3'b111, 3'd2, 6'b100100};
    vecs[11] = '{1'b0, 3'b011, 3'd3, 6'b000110};

    bif.enable      = 1'b0;
    bif.fwd         = 1'b1;
    bif.mode        = 1'b0;
    bif.hall        = 3'b001;
    bif.duty        = 8'hFF;
    bif.step_period = 24'(STEP);
    bif.fault_clr   = 1'b0;

    #22;
    check("reset_gate", bif.gate, 0);
    check("reset_sector", bif.sector, 0);
    check("reset_fault", bif.fault, 0);
    rst_n = 1'b1;
    tick(300);
    check("off_gate", bif.gate, 0);

    bif.enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bif.fwd  = vecs[i].fwd;
      bif.hall = vecs[i].hall;
      sb.push_back('{$sformatf("vec%0d", i), vecs[i].sector, vecs[i].pattern});
      tick(SETTLE);
      gate_or(4, acc);
      e = sb.pop_front();
      check({e.name, "_sector"}, bif.sector, e.sector);
      check({e.name, "_gate"}, acc, e.pattern);
    end

    // Sector 1 -> 2 with exact hall latency and dead-time window
    bif.fwd  = 1'b1;
    bif.hall = 3'b001;
    tick(SETTLE);
    check("s1_sector", bif.sector, 1);
    bif.hall = 3'b000;
    tick(HLAT - 1);
    check("s1_hold_lowside", bif.gate[0], 1);
    tick(1);
    check("dead_start_gate", bif.gate, 0);
    tick(DEADTIME - 1);
    check("dead_end_gate", bif.gate, 0);
    tick(1);
    check("s2_sector", bif.sector, 2);
    check("s2_lowside", bif.gate & 6'b010101, 6'b000100);

    // Reverse direction, then toggle fwd
    bif.fwd  = 1'b0;
    bif.hall = 3'b001;
    tick(SETTLE);
    check("rev_sector", bif.sector, 4);
    check("rev_lowside", bif.gate & 6'b010101, 6'b010000);
    bif.fwd = 1'b1;
    tick(1);
    check("fwd_toggle_dead", bif.gate, 0);
    tick(DEADTIME - 1);
    check("fwd_toggle_dead_end", bif.gate, 0);
    tick(1);
    check("fwd_toggle_sector", bif.sector, 1);

    // Invalid hall fault and clearing
    bif.hall = 3'b101;
    tick(HLAT - 1);
    check("inv_pre_fault", bif.fault, 0);
    tick(1);
    check("inv_fault", bif.fault, 1);
    check("inv_gate", bif.gate, 0);
    check("inv_sector", bif.sector, 0);
    bif.fault_clr = 1'b1;
    tick(3);
    check("clr_while_enabled", bif.fault, 1);
    bif.enable = 1'b0;
    tick(1);
    check("clr_disabled", bif.fault, 0);
    bif.fault_clr = 1'b0;

    // Stall timeout (and glitch rejection when filtered)
    bif.hall = 3'b110;
    tick(HLAT + 2);
    bif.enable = 1'b1;
    tick(1 + DEADTIME);
    check("stall_sector", bif.sector, 4);
    el = 0;
`ifdef HALL_FILTER_EN
    tick(100);
    bif.hall = 3'b010;
    tick(2);
    bif.hall = 3'b110;
    tick(20);
    check("glitch_fault", bif.fault, 0);
    check("glitch_sector", bif.sector, 4);
    el = 122;
`endif
    tick(TIMEOUT - 1 - el);
    check("stall_pre", bif.fault, 0);
    tick(1);
    check("stall_fault", bif.fault, 1);
    check("stall_gate", bif.gate, 0);

    bif.enable    = 1'b0;
    bif.fault_clr = 1'b1;
    tick(1);
    bif.fault_clr = 1'b0;
    check("stall_clr", bif.fault, 0);

    // Open-loop forward stepping
    bif.mode = 1'b1;
    bif.fwd  = 1'b1;
    tick(2);
    for (int s = 1; s <= 7; s++)
      sb.push_back('{$sformatf("ol%0d", s), 3'((s - 1) % 6 + 1), 6'b000000});
    bif.enable = 1'b1;
    tick(1 + DEADTIME);
    e = sb.pop_front();
    check({e.name, "_sector"}, bif.sector, e.sector);
    check("ol1_lowside", bif.gate & 6'b010101, 6'b000001);
    for (int k = 0; k < 6; k++) begin
      tick(STEP - DEADTIME);
      check("ol_dead_start", bif.gate, 0);
      tick(DEADTIME - 1);
      check("ol_dead_end", bif.gate, 0);
      tick(1);
      e = sb.pop_front();
      check({e.name, "_sector"}, bif.sector, e.sector);
    end

    // PWM duty on A+ while parked in sector 1
    bif.step_period = '1;
    count_high(256, cnt);
    check("pwm_full", cnt, 255);
    bif.duty = 8'h00;
    tick(260);
    count_high(256, cnt);
    check("pwm_zero", cnt, 0);
    bif.duty = 8'h40;
    tick(260);
    count_high(256, cnt);
    check("pwm_quarter", cnt, 64);
    check("pwm_sector_hold", bif.sector, 1);

    // Asynchronous reset mid-DRIVE
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_gate", bif.gate, 0);
    check("async_rst_sector", bif.sector, 0);
    check("async_rst_fault", bif.fault, 0);
    bif.enable = 1'b0;
    #10;
    rst_n = 1'b1;
    tick(3);
    check("post_rst_gate", bif.gate, 0);
    check("post_rst_sector", bif.sector, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
